// File: rtl/bcd_pkg.sv
// ============================================================================
// Module : bcd_pkg
// Shared state encoding and digit constants for the sequential BCD converter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } bcd_state_t;

    localparam int DIGIT_W    = 4;
    localparam int ADJ_THRESH = 5;
    localparam int ADJ_ADD    = 3;

endpackage

`default_nettype wire

// File: rtl/bcd_add3.sv
// ============================================================================
// Module : bcd_add3
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din_i,
    output logic [DIGIT_W-1:0] dout_o
);

    always_comb begin
        dout_o = din_i;
        if (din_i >= DIGIT_W'(ADJ_THRESH)) begin
            dout_o = din_i + DIGIT_W'(ADJ_ADD);
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_bin_to_bcd.sv
// ============================================================================
// Module : seq_bin_to_bcd
// Sequential shift-and-add-3 binary to BCD converter with sticky overflow.
// Optional leading-zero mask enabled by macro SEQ_BIN_TO_BCD_BLANK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_bin_to_bcd
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 5
)
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [BIN_W-1:0]            binary,
    output logic                        busy,
    output logic                        done,
    output logic [DIGIT_W*DIGITS-1:0]   bcd,
    output logic                        overflow,
    output logic [DIGITS-1:0]           blank
);

    localparam int                BCD_W     = DIGIT_W * DIGITS;
    localparam int                CNT_W     = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BIN_W - 1);
    localparam logic [BCD_W-1:0]  ALL_NINES = {DIGITS{4'h9}};

    bcd_state_t         state_q, state_d;
    logic [BIN_W-1:0]   shreg_q, shreg_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic [BCD_W-1:0]   w_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sticky_q, sticky_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               load_res;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3 u_add3 (
            .din_i  (work_q[g*DIGIT_W +: DIGIT_W]),
            .dout_o (w_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        load_res = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SHIFT;
                    shreg_d  = binary;
                    work_d   = '0;
                    cnt_d    = '0;
                    sticky_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                // A 1 leaving the top digit means the value needs more digits.
                shreg_d  = {shreg_q[BIN_W-2:0], 1'b0};
                work_d   = {w_adj[BCD_W-2:0], shreg_q[BIN_W-1]};
                sticky_d = sticky_q | w_adj[BCD_W-1];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d  = ST_DONE;
                    load_res = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Results are captured from the final shift so they are valid throughout DONE.
    always_comb begin
        bcd_d = bcd_q;
        ovf_d = ovf_q;
        if (load_res) begin
            ovf_d = sticky_d;
            bcd_d = sticky_d ? ALL_NINES : work_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef SEQ_BIN_TO_BCD_BLANK_EN
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    logic [DIGITS-1:0] blank_q, blank_d;
    logic              lead_zero;

    // Walk from the most significant digit down; the units digit never blanks.
    always_comb begin
        blank_d   = blank_q;
        lead_zero = 1'b1;
        if (load_res) begin
            blank_d   = '0;
            lead_zero = ~sticky_d;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                lead_zero  = lead_zero & (work_d[i*DIGIT_W +: DIGIT_W] == '0);
                blank_d[i] = lead_zero;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blank_q <= BLANK_RST;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

    assign busy     = (state_q == ST_SHIFT);
    assign done     = (state_q == ST_DONE);
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_bin_to_bcd.sv
// ============================================================================
// Module : tb_seq_bin_to_bcd
// Self-checking bench: three converter configurations against a decimal model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_seq_bin_to_bcd;

    localparam int NI = 3;

`ifdef SEQ_BIN_TO_BCD_BLANK_EN
    localparam bit BLK = 1'b1;
`else
    localparam bit BLK = 1'b0;
`endif

    typedef struct packed {
        logic [39:0] bcd;
        logic        ovf;
        logic [9:0]  blank;
    } res_t;

    function automatic int bw(int k);
        return (k == 2) ? 8 : 14;
    endfunction

    function automatic int dg(int k);
        return (k == 0) ? 5 : ((k == 1) ? 4 : 3);
    endfunction

    // Decimal reference: digits by repeated division, overflow by magnitude.
    function automatic res_t ref_conv(longint unsigned v, int d);
        res_t            r;
        longint unsigned lim;
        longint unsigned x;
        longint unsigned p;
        r   = '0;
        lim = 1;
        x   = v;
        for (int i = 0; i < d; i++) lim = lim * 10;
        if (v >= lim) begin
            r.ovf = 1'b1;
            for (int i = 0; i < d; i++) r.bcd[i*4 +: 4] = 4'd9;
        end else begin
            for (int i = 0; i < d; i++) begin
                r.bcd[i*4 +: 4] = 4'(x % 10);
                x = x / 10;
            end
            if (BLK) begin
                p = 10;
                for (int i = 1; i < d; i++) begin
                    r.blank[i] = (v < p);
                    p = p * 10;
                end
            end
        end
        return r;
    endfunction

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_v[NI];
    logic [31:0] bin_v[NI];
    logic        chk_en = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    logic        busy0, busy1, busy2, done0, done1, done2, ovf0, ovf1, ovf2;
    logic [19:0] bcd0;
    logic [15:0] bcd1;
    logic [11:0] bcd2;
    logic [4:0]  blank0;
    logic [3:0]  blank1;
    logic [2:0]  blank2;

    seq_bin_to_bcd #(.BIN_W(14), .DIGITS(5)) u_dut (
        .clk(clk), .reset(reset), .start(start_v[0]), .binary(bin_v[0][13:0]),
        .busy(busy0), .done(done0), .bcd(bcd0), .overflow(ovf0), .blank(blank0)
    );
    seq_bin_to_bcd #(.BIN_W(14), .DIGITS(4)) u_d4 (
        .clk(clk), .reset(reset), .start(start_v[1]), .binary(bin_v[1][13:0]),
        .busy(busy1), .done(done1), .bcd(bcd1), .overflow(ovf1), .blank(blank1)
    );
    seq_bin_to_bcd #(.BIN_W(8), .DIGITS(3)) u_b8 (
        .clk(clk), .reset(reset), .start(start_v[2]), .binary(bin_v[2][7:0]),
        .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2), .blank(blank2)
    );

    logic [39:0] d_bcd[NI];
    logic [9:0]  d_blank[NI];
    logic        d_busy[NI], d_done[NI], d_ovf[NI];

    always_comb begin
        d_bcd[0] = 40'(bcd0);     d_bcd[1] = 40'(bcd1);     d_bcd[2] = 40'(bcd2);
        d_blank[0] = 10'(blank0); d_blank[1] = 10'(blank1); d_blank[2] = 10'(blank2);
        d_busy[0] = busy0; d_busy[1] = busy1; d_busy[2] = busy2;
        d_done[0] = done0; d_done[1] = done1; d_done[2] = done2;
        d_ovf[0] = ovf0;   d_ovf[1] = ovf1;   d_ovf[2] = ovf2;
    end

    task automatic chk(string nm, logic [39:0] act, logic [39:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: m_p counts conversion phase; 1..BIN_W busy, BIN_W+1 done cycle.
    int   m_p[NI] = '{0, 0, 0};
    res_t m_out[NI];
    res_t m_exp[NI];

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (reset) begin
                m_p[k]   <= 0;
                m_out[k] <= ref_conv(0, dg(k));
            end else if (m_p[k] == 0) begin
                if (start_v[k]) begin
                    m_p[k]   <= 1;
                    m_exp[k] <= ref_conv({32'd0, bin_v[k]} % (64'd1 << bw(k)), dg(k));
                end
            end else if (m_p[k] <= bw(k)) begin
                m_p[k] <= m_p[k] + 1;
                if (m_p[k] == bw(k)) m_out[k] <= m_exp[k];
            end else begin
                m_p[k] <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("busy[%0d]", k), 40'(d_busy[k]), 40'(m_p[k] >= 1 && m_p[k] <= bw(k)));
                chk($sformatf("done[%0d]", k), 40'(d_done[k]), 40'(m_p[k] == bw(k) + 1));
                chk($sformatf("bcd[%0d]", k), d_bcd[k], m_out[k].bcd);
                chk($sformatf("ovf[%0d]", k), 40'(d_ovf[k]), 40'(m_out[k].ovf));
                chk($sformatf("blank[%0d]", k), 40'(d_blank[k]), 40'(m_out[k].blank));
            end
        end
    end

    task automatic wait_done(int k, int budget, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!d_done[k] && lat < budget);
        if (!d_done[k]) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout[%0d]: got no done, required done within %0d cycles", k, budget);
        end
    endtask

    task automatic conv(int k, longint unsigned v, output int lat);
        int wl;
        @(negedge clk);
        bin_v[k]   = 32'(v);
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        wait_done(k, 60, wl);
        lat = wl + 1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   busy_cnt;
        int   done_cnt;
        res_t r;
        for (int k = 0; k < NI; k++) begin
            start_v[k] = 1'b0;
            bin_v[k]   = '0;
        end
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_bcd", d_bcd[0], 40'h0);
        chk("rst_busy", 40'(busy0), 40'h0);
        chk("rst_ovf", 40'(ovf0), 40'h0);
        chk("rst_blank", 40'(blank0), BLK ? 40'h1E : 40'h0);
        reset = 1'b0;

        r = ref_conv(9999, 5);
        chk("model_9999", r.bcd, 40'h09999);
        r = ref_conv(12345, 4);
        chk("model_ovf", 40'(r.ovf), 40'h1);
        r = ref_conv(255, 3);
        chk("model_255", r.bcd, 40'h255);

        conv(0, 9999, lat);
        chk("lat_9999", 40'(lat), 40'd15);
        chk("bcd_9999", d_bcd[0], 40'h09999);
        chk("ovf_9999", 40'(ovf0), 40'h0);
        chk("blank_9999", 40'(blank0), BLK ? 40'h10 : 40'h0);

        conv(0, 16383, lat);
        chk("bcd_16383", d_bcd[0], 40'h16383);
        chk("blank_16383", 40'(blank0), 40'h0);
        conv(0, 0, lat);
        chk("bcd_zero", d_bcd[0], 40'h0);
        chk("ovf_zero", 40'(ovf0), 40'h0);
        chk("blank_zero", 40'(blank0), BLK ? 40'h1E : 40'h0);

        conv(1, 12345, lat);
        chk("ovf_d4", 40'(ovf1), 40'h1);
        chk("bcd_d4", d_bcd[1], 40'h9999);
        chk("blank_d4", 40'(blank1), 40'h0);

        // Start re-asserted mid-conversion must be ignored.
        @(negedge clk);
        bin_v[0] = 42; start_v[0] = 1'b1;
        busy_cnt = 0; done_cnt = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            busy_cnt += int'(busy0);
            done_cnt += int'(done0);
            if (c == 1) start_v[0] = 1'b0;
            if (c == 5) begin bin_v[0] = 7; start_v[0] = 1'b1; end
            if (c == 8) start_v[0] = 1'b0;
        end
        chk("ign_busy_cycles", 40'(busy_cnt), 40'd14);
        chk("ign_done_count", 40'(done_cnt), 40'd1);
        chk("ign_bcd", d_bcd[0], 40'h00042);

        // Reset mid-conversion aborts without a done pulse.
        @(negedge clk);
        bin_v[0] = 500; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        done_cnt = 0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            done_cnt += int'(done0);
        end
        chk("abort_done", 40'(done_cnt), 40'd0);
        chk("abort_bcd", d_bcd[0], 40'h0);
        chk("abort_busy", 40'(busy0), 40'h0);
        conv(0, 8, lat);
        chk("after_abort_bcd", d_bcd[0], 40'h00008);

        // Back-to-back sweep of the 8-bit configuration.
        @(negedge clk);
        bin_v[2] = 0; start_v[2] = 1'b1;
        for (int v = 0; v < 256; v++) begin
            wait_done(2, 40, lat);
            chk("sweep_period", 40'(lat), (v == 0) ? 40'd9 : 40'd10);
            bin_v[2] = 32'(v + 1);
            if (v == 255) start_v[2] = 1'b0;
        end
        chk("sweep_last", d_bcd[2], 40'h255);

        // Random start pulses, binary churn and occasional resets.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                start_v[k] = ($urandom_range(0, 3) == 0);
                bin_v[k]   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 120)) : $urandom;
            end
            reset = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < NI; k++) start_v[k] = 1'b0;
        repeat (25) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
